// File: rtl/icache_responder.sv
// icache_responder: read-only direct-mapped instruction cache between the
// fetch stage and the memory arbiter. Lines are 64 B, refilled as four
// 128-bit beats. A hit answers one cycle after acceptance. A miss stalls
// fetch through cpu_req_ready while the line is fetched, then replays the
// requested word.
// The lookup runs on the incoming address in the accepting cycle, so every
// CPU-facing output is driven straight from a flop.
// Optional build macro: ICACHE_STATS_EN adds 32-bit hit_count / miss_count.
module icache_responder #(
    parameter int LINES         = 64,
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_ADDR_BITS = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              cpu_req_addr,
    input  logic                     cpu_req_valid,
    output logic                     cpu_req_ready,
    output logic                     cpu_resp_valid,
    output logic [31:0]              cpu_resp_data,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_resp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int OFFSET_BITS = 6;
    localparam int INDEX_BITS  = $clog2(LINES);
    localparam int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MISS_REQ = 2'd1,
        REFILL   = 2'd2,
        REPLAY   = 2'd3
    } state_t;

    // Pick one 32-bit instruction word out of a 128-bit beat.
    function automatic logic [31:0] word_of(input logic [MEM_DATA_BITS-1:0] beat,
                                            input logic [1:0]               sel);
        logic [31:0] w;
        case (sel)
            2'd0:    w = beat[31:0];
            2'd1:    w = beat[63:32];
            2'd2:    w = beat[95:64];
            2'd3:    w = beat[127:96];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Registered state
    state_t                        state_r;
    logic [31:0]                   req_addr_r;
    logic                          req_pending_r;
    logic                          lookup_hit_r;
    logic [1:0]                    beat_cnt_r;
    logic                          resp_valid_r;
    logic [31:0]                   resp_data_r;
    logic                          req_ready_r;
    logic                          mem_req_valid_r;
    logic [LINES-1:0]              valid_r;
    logic [TAG_BITS-1:0]           tag_r       [LINES];
    logic [3:0][MEM_DATA_BITS-1:0] line_data_r [LINES];

    // Next-state values
    state_t                        state_s;
    logic [31:0]                   req_addr_s;
    logic                          req_pending_s;
    logic                          lookup_hit_s;
    logic [1:0]                    beat_cnt_s;
    logic                          resp_valid_s;
    logic [31:0]                   resp_data_s;
    logic                          req_ready_s;
    logic                          mem_req_valid_s;
    logic                          fill_we_s;
    logic                          fill_done_s;
    logic                          open_s;
    logic                          hit_evt_s;
    logic                          miss_evt_s;

    // Lookup of the incoming address and decode of the held address
    logic                          accept_s;
    logic [INDEX_BITS-1:0]         in_index_s;
    logic [TAG_BITS-1:0]           in_tag_s;
    logic                          in_hit_s;
    logic [31:0]                   in_data_s;
    logic [INDEX_BITS-1:0]         req_index_s;
    logic [TAG_BITS-1:0]           req_tag_s;
    logic [1:0]                    req_beat_s;
    logic [1:0]                    req_word_s;
    logic [MEM_DATA_BITS-1:0]      replay_beat_s;
    logic [31:0]                   replay_data_s;
    logic                          unused_bits_s;

    assign accept_s    = cpu_req_valid && req_ready_r;

    assign in_index_s  = cpu_req_addr[OFFSET_BITS +: INDEX_BITS];
    assign in_tag_s    = cpu_req_addr[31 -: TAG_BITS];
    assign in_hit_s    = valid_r[in_index_s] && (tag_r[in_index_s] == in_tag_s);
    assign in_data_s   = word_of(line_data_r[in_index_s][cpu_req_addr[5:4]], cpu_req_addr[3:2]);

    assign req_index_s = req_addr_r[OFFSET_BITS +: INDEX_BITS];
    assign req_tag_s   = req_addr_r[31 -: TAG_BITS];
    assign req_beat_s  = req_addr_r[5:4];
    assign req_word_s  = req_addr_r[3:2];

    // The last beat is not in the array yet when the replay word is captured.
    assign replay_beat_s = (req_beat_s == 2'd3) ? mem_resp_data
                                                : line_data_r[req_index_s][req_beat_s];
    assign replay_data_s = word_of(replay_beat_s, req_word_s);

    assign cpu_req_ready  = req_ready_r;
    assign cpu_resp_valid = resp_valid_r;
    assign cpu_resp_data  = resp_data_r;
    assign mem_req_valid  = mem_req_valid_r;
    assign mem_req_rw     = 1'b0;
    assign mem_req_addr   = {req_addr_r[31:OFFSET_BITS], 2'b00};

    assign unused_bits_s  = ^{cpu_req_addr[1:0], req_addr_r[1:0]};

    // Next-state and next-output logic for the refill state machine
    always_comb begin
        state_s         = state_r;
        req_addr_s      = req_addr_r;
        req_pending_s   = req_pending_r;
        lookup_hit_s    = lookup_hit_r;
        beat_cnt_s      = beat_cnt_r;
        resp_valid_s    = 1'b0;
        resp_data_s     = resp_data_r;
        req_ready_s     = req_ready_r;
        mem_req_valid_s = 1'b0;
        fill_we_s       = 1'b0;
        fill_done_s     = 1'b0;
        open_s          = 1'b0;
        hit_evt_s       = 1'b0;
        miss_evt_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (req_pending_r && !lookup_hit_r) begin
                    state_s         = MISS_REQ;
                    mem_req_valid_s = 1'b1;
                    req_ready_s     = 1'b0;
                    miss_evt_s      = 1'b1;
                end else begin
                    hit_evt_s = req_pending_r;
                    open_s    = 1'b1;
                end
            end
            MISS_REQ: begin
                req_ready_s = 1'b0;
                if (mem_req_ready) begin
                    state_s    = REFILL;
                    beat_cnt_s = 2'd0;
                end else begin
                    mem_req_valid_s = 1'b1;
                end
            end
            REFILL: begin
                req_ready_s = 1'b0;
                if (mem_resp_valid) begin
                    fill_we_s  = 1'b1;
                    beat_cnt_s = beat_cnt_r + 2'd1;
                    if (beat_cnt_r == 2'd3) begin
                        fill_done_s  = 1'b1;
                        state_s      = REPLAY;
                        resp_valid_s = 1'b1;
                        resp_data_s  = replay_data_s;
                        req_ready_s  = 1'b1;
                    end else begin
                        state_s = REFILL;
                    end
                end else begin
                    state_s = REFILL;
                end
            end
            REPLAY: begin
                state_s = IDLE;
                open_s  = 1'b1;
            end
            default: begin
                state_s       = IDLE;
                req_pending_s = 1'b0;
                req_ready_s   = 1'b1;
            end
        endcase

        // Ready cycle: take a new request and look it up right away.
        if (open_s) begin
            if (accept_s) begin
                req_addr_s    = cpu_req_addr;
                req_pending_s = 1'b1;
                lookup_hit_s  = in_hit_s;
                resp_valid_s  = in_hit_s;
                resp_data_s   = in_hit_s ? in_data_s : resp_data_r;
                req_ready_s   = in_hit_s;
            end else begin
                req_pending_s = 1'b0;
                lookup_hit_s  = 1'b0;
                req_ready_s   = 1'b1;
            end
        end else begin
            open_s = 1'b0;
        end
    end

    // Control registers, valid bits and tags; reset drops every line
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            req_addr_r      <= 32'd0;
            req_pending_r   <= 1'b0;
            lookup_hit_r    <= 1'b0;
            beat_cnt_r      <= 2'd0;
            resp_valid_r    <= 1'b0;
            resp_data_r     <= 32'd0;
            req_ready_r     <= 1'b1;
            mem_req_valid_r <= 1'b0;
            valid_r         <= '0;
        end else begin
            state_r         <= state_s;
            req_addr_r      <= req_addr_s;
            req_pending_r   <= req_pending_s;
            lookup_hit_r    <= lookup_hit_s;
            beat_cnt_r      <= beat_cnt_s;
            resp_valid_r    <= resp_valid_s;
            resp_data_r     <= resp_data_s;
            req_ready_r     <= req_ready_s;
            mem_req_valid_r <= mem_req_valid_s;
            if (fill_done_s) begin
                valid_r[req_index_s] <= 1'b1;
                tag_r[req_index_s]   <= req_tag_s;
            end
        end
    end

    // Line data array: each refill beat lands in its slot of the target line
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            line_data_r[req_index_s][beat_cnt_r] <= mem_resp_data;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;

    // Hit and miss event counters, free-running and wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if (hit_evt_s) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if (miss_evt_s) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end
`else
    logic unused_stats_s;
    assign unused_stats_s = hit_evt_s ^ miss_evt_s;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Testbench for icache_responder: directed fetch sequences with a
// scoreboard queue of expected instruction words and a memory responder.
// Memory word at byte address A holds {8'hC0, A[23:0]}.
module tb_icache_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  cpu_req_addr;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_data;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int           pass_cnt = 0;
    int           total_cnt = 0;
    logic [31:0]  exp_q [$];
    logic [31:0]  mon_exp;

    always #5 clk = ~clk;

    icache_responder dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_data (cpu_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && cpu_resp_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL resp_unexpected: actual %h required no response", cpu_resp_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("resp_data", cpu_resp_data, mon_exp);
            end
        end
    end

    function automatic logic [127:0] make_beat(input logic [31:0] addr, input int k);
        logic [127:0] b;
        logic [31:0]  a;
        b = '0;
        for (int w = 0; w < 4; w++) begin
            a = {addr[31:6], 6'd0} + 32'(k * 16 + w * 4);
            b[w*32 +: 32] = {8'hC0, a[23:0]};
        end
        return b;
    endfunction

    // Present one request for one cycle; optionally queue its expected word.
    task automatic issue(input logic [31:0] a, input logic [31:0] exp_word, input bit push);
        int t;
        t = 0;
        while (!cpu_req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cpu_req_ready) begin
            check("issue_ready_timeout", 32'(cpu_req_ready), 32'd1);
        end
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        if (push) begin
            exp_q.push_back(exp_word);
        end
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    // Memory side of one miss: wait for the request, stall it, stream beats.
    // abort=1 asserts reset after two beats and then sends two stray beats.
    task automatic serve_miss(input logic [31:0] addr, input int rdly, input int gap, input bit abort);
        int          t;
        logic [27:0] exp_maddr;
        exp_maddr = {addr[31:6], 2'b00};
        t = 0;
        while (!mem_req_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!mem_req_valid) begin
            check("mem_req_timeout", 32'(mem_req_valid), 32'd1);
            return;
        end
        check("mem_req_addr", 32'(mem_req_addr), 32'(exp_maddr));
        check("mem_req_rw", 32'(mem_req_rw), 32'd0);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check("mem_req_valid_hold", 32'(mem_req_valid), 32'd1);
            check("mem_req_addr_hold", 32'(mem_req_addr), 32'(exp_maddr));
            check("stall_ready", 32'(cpu_req_ready), 32'd0);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("single_mem_req", 32'(mem_req_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b0;
            if (abort && k == 2) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("abort_ready", 32'(cpu_req_ready), 32'd1);
                check("abort_mem_req", 32'(mem_req_valid), 32'd0);
                for (int j = 0; j < 2; j++) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = make_beat(addr, 2 + j);
                    @(negedge clk);
                    check("stray_resp_valid", 32'(cpu_resp_valid), 32'd0);
                    check("stray_mem_req", 32'(mem_req_valid), 32'd0);
                    check("stray_ready", 32'(cpu_req_ready), 32'd1);
                end
                mem_resp_valid = 1'b0;
                return;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("gap_ready", 32'(cpu_req_ready), 32'd0);
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = make_beat(addr, k);
            check("refill_ready", 32'(cpu_req_ready), 32'd0);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        check("replay_valid", 32'(cpu_resp_valid), 32'd1);
        check("replay_ready", 32'(cpu_req_ready), 32'd1);
    endtask

    // Absolute time limit for the whole run
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Directed test sequence
    initial begin
        logic [31:0] hit_addr [3];
        logic [31:0] hit_word [3];
        hit_addr = '{32'h0000_0040, 32'h0000_0048, 32'h0000_007C};
        hit_word = '{32'hC000_0040, 32'hC000_0048, 32'hC000_007C};

        reset          = 1'b1;
        cpu_req_valid  = 1'b0;
        cpu_req_addr   = 32'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cpu_req_ready), 32'd1);
        check("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("rst_resp_data", cpu_resp_data, 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Cold miss on 0x44, memory answers immediately
        issue(32'h0000_0044, 32'hC000_0044, 1'b1);
        check("cold_miss_ready", 32'(cpu_req_ready), 32'd0);
        serve_miss(32'h0000_0044, 0, 0, 1'b0);

        // Back-to-back hits in the freshly filled line (first one taken in REPLAY)
        for (int i = 0; i < 3; i++) begin
            check("hit_ready", 32'(cpu_req_ready), 32'd1);
            cpu_req_valid = 1'b1;
            cpu_req_addr  = hit_addr[i];
            exp_q.push_back(hit_word[i]);
            @(negedge clk);
            check("hit_resp_valid", 32'(cpu_resp_valid), 32'd1);
            check("hit_no_mem_req", 32'(mem_req_valid), 32'd0);
        end
        cpu_req_valid = 1'b0;
        check("hit_ready_after", 32'(cpu_req_ready), 32'd1);
        @(negedge clk);
        check("hit_idle_no_resp", 32'(cpu_resp_valid), 32'd0);
`ifdef ICACHE_STATS_EN
        check("stat_hit_count", hit_count, 32'd3);
        check("stat_miss_count", miss_count, 32'd1);
`endif

        // Conflict eviction on index 1
        issue(32'h0000_1040, 32'hC000_1040, 1'b1);
        check("conflict_miss_ready", 32'(cpu_req_ready), 32'd0);
        serve_miss(32'h0000_1040, 0, 0, 1'b0);
        issue(32'h0000_0040, 32'hC000_0040, 1'b1);
        check("evicted_miss_ready", 32'(cpu_req_ready), 32'd0);
        serve_miss(32'h0000_0040, 0, 0, 1'b0);

        // Slow memory: request stalled 5 cycles, beats 3 cycles apart
        issue(32'h0000_2088, 32'hC000_2088, 1'b1);
        serve_miss(32'h0000_2088, 5, 3, 1'b0);

        // Reset in the middle of a refill, then stray beats
        issue(32'h0000_30C4, 32'd0, 1'b0);
        serve_miss(32'h0000_30C4, 0, 0, 1'b1);
`ifdef ICACHE_STATS_EN
        check("abort_hit_count", hit_count, 32'd0);
        check("abort_miss_count", miss_count, 32'd0);
`endif
        issue(32'h0000_30C4, 32'hC000_30C4, 1'b1);
        check("refetch_miss_ready", 32'(cpu_req_ready), 32'd0);
        serve_miss(32'h0000_30C4, 0, 0, 1'b0);

        // Every line was dropped by reset, including the old 0x40 line
        issue(32'h0000_0044, 32'hC000_0044, 1'b1);
        check("invalidated_miss_ready", 32'(cpu_req_ready), 32'd0);
        serve_miss(32'h0000_0044, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
